gpu_line_raster: RTL

Parametrised Bresenham line rasteriser for the GPU draw pipeline. Accepts one line command (signed endpoints plus colour) over a valid/ready handshake and emits one pixel per cycle on a valid/ready pixel stream toward the framebuffer writer. Supports all octants, endpoints outside the screen, clipping to screen bounds, output backpressure and abort.

---
 rtl/gpu_raster_pkg.sv | 21 ++
 rtl/gpu_bresenham_step.sv | 37 +++
 rtl/gpu_line_raster.sv | 118 +++++++++++
 3 files changed

// File: rtl/gpu_raster_pkg.sv
// Shared types for the line rasteriser: FSM states, coordinate width helper, pixel word.
package gpu_raster_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, STEP, FINISH} state_t;

    localparam int PX_W_BITS     = 10;
    localparam int PX_H_BITS     = 9;
    localparam int PX_COLOR_BITS = 24;

    // Signed coordinate width: wide enough for off-screen endpoints on either axis.
    function automatic int coord_width(input int w_bits, input int h_bits);
        return ((w_bits > h_bits) ? w_bits : h_bits) + 2;
    endfunction

    typedef struct packed {
        logic [PX_W_BITS-1:0]     x;
        logic [PX_H_BITS-1:0]     y;
        logic [PX_COLOR_BITS-1:0] color;
    } pixel_t;

endpackage

// File: rtl/gpu_bresenham_step.sv
// One combinational Bresenham advance: (x, y, err) -> next (x, y, err).
module gpu_bresenham_step #(
    parameter int CW = 12
) (
    input  logic signed [CW-1:0] x,
    input  logic signed [CW-1:0] y,
    input  logic signed [CW+1:0] err,
    input  logic signed [CW+1:0] dx,
    input  logic signed [CW+1:0] dy,
    input  logic                 sx_neg,
    input  logic                 sy_neg,
    output logic signed [CW-1:0] nx,
    output logic signed [CW-1:0] ny,
    output logic signed [CW+1:0] nerr
);

    localparam logic signed [CW-1:0] ONE = CW'(1);

    logic signed [CW+1:0] e2;

    // Both axis tests use the pre-update e2, so a diagonal step applies both terms.
    always_comb begin
        e2   = err <<< 1;
        nerr = err;
        nx   = x;
        ny   = y;
        if (e2 >= dy) begin
            nerr = nerr + dy;
            nx   = sx_neg ? x - ONE : x + ONE;
        end
        if (e2 <= dx) begin
            nerr = nerr + dx;
            ny   = sy_neg ? y - ONE : y + ONE;
        end
    end

endmodule

// File: rtl/gpu_line_raster.sv
// Bresenham line rasteriser: one command in, one clipped pixel per cycle out.
module gpu_line_raster
    import gpu_raster_pkg::*;
#(
    parameter int W_BITS     = 10,
    parameter int H_BITS     = 9,
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480,
    parameter int COLOR_BITS = 24
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic signed [W_BITS+1:0]     cmd_x1,
    input  logic signed [H_BITS+1:0]     cmd_y1,
    input  logic signed [W_BITS+1:0]     cmd_x2,
    input  logic signed [H_BITS+1:0]     cmd_y2,
    input  logic [COLOR_BITS-1:0]        cmd_color,
    input  logic                         abort,
    output logic                         px_valid,
    input  logic                         px_ready,
    output logic [W_BITS-1:0]            px_x,
    output logic [H_BITS-1:0]            px_y,
    output logic [COLOR_BITS-1:0]        px_color,
    output logic                         busy,
    output logic                         done
);

    localparam int CW = coord_width(W_BITS, H_BITS);
    localparam int EW = CW + 2;
    localparam logic signed [CW-1:0] MAX_X = CW'(SCREEN_W);
    localparam logic signed [CW-1:0] MAX_Y = CW'(SCREEN_H);

    state_t                 state;
    logic signed [CW-1:0]   cur_x, cur_y, end_x, end_y, nxt_x, nxt_y;
    logic signed [EW-1:0]   err, dx, dy, nxt_err, dif_x, dif_y, abs_x, abs_y;
    logic                   sx_neg, sy_neg, on_screen, at_end, consume;
    logic [COLOR_BITS-1:0]  color;

    assign dif_x     = EW'(end_x) - EW'(cur_x);
    assign dif_y     = EW'(end_y) - EW'(cur_y);
    assign abs_x     = dif_x[EW-1] ? -dif_x : dif_x;
    assign abs_y     = dif_y[EW-1] ? -dif_y : dif_y;
    assign on_screen = !cur_x[CW-1] && (cur_x < MAX_X) && !cur_y[CW-1] && (cur_y < MAX_Y);
    assign at_end    = (cur_x == end_x) && (cur_y == end_y);
    // Off-screen points retire without a handshake; on-screen ones wait for px_ready.
    assign consume   = on_screen ? px_ready : 1'b1;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = (state == FINISH);
    assign px_valid  = (state == STEP) && on_screen;
    assign px_x      = cur_x[W_BITS-1:0];
    assign px_y      = cur_y[H_BITS-1:0];
    assign px_color  = color;

    gpu_bresenham_step #(.CW(CW)) u_step (
        .x      (cur_x),
        .y      (cur_y),
        .err    (err),
        .dx     (dx),
        .dy     (dy),
        .sx_neg (sx_neg),
        .sy_neg (sy_neg),
        .nx     (nxt_x),
        .ny     (nxt_y),
        .nerr   (nxt_err)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state  <= IDLE;
            cur_x  <= '0;
            cur_y  <= '0;
            end_x  <= '0;
            end_y  <= '0;
            err    <= '0;
            dx     <= '0;
            dy     <= '0;
            sx_neg <= 1'b0;
            sy_neg <= 1'b0;
            color  <= '0;
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    cur_x <= CW'(cmd_x1);
                    cur_y <= CW'(cmd_y1);
                    end_x <= CW'(cmd_x2);
                    end_y <= CW'(cmd_y2);
                    color <= cmd_color;
                    state <= SETUP;
                end
                SETUP: if (abort) state <= IDLE;
                else begin
                    dx     <= abs_x;
                    dy     <= -abs_y;
                    err    <= abs_x - abs_y;
                    sx_neg <= !(cur_x < end_x);
                    sy_neg <= !(cur_y < end_y);
                    state  <= STEP;
                end
                STEP: if (abort) state <= IDLE;
                else if (consume) begin
                    if (at_end) state <= FINISH;
                    else begin
                        cur_x <= nxt_x;
                        cur_y <= nxt_y;
                        err   <= nxt_err;
                    end
                end
                FINISH: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
